uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with a small transmit FIFO.
//
// Frame: one start bit (0), DATA_BITS data bits LSB first, an optional
// parity bit (PARITY: 0 none, 1 odd, 2 even), then STOP_BITS stop bits (1).
// Each level on tx is launched on a clken cycle and holds until the next one.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - synchronous active-low reset
//   din        - data word to queue (DATA_BITS wide)
//   wr_en      - one-cycle write strobe for din
//   clken      - bit-rate enable, one pulse per bit period
//   tx         - serial line, idles high (registered)
//   tx_busy    - a frame is in progress or words are queued
//   fifo_full  - FIFO holds FIFO_DEPTH words
//   fifo_empty - FIFO holds no words
//   overflow   - one-cycle pulse, the cycle after a write was dropped
module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  input  logic                 clken,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_e;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overflow_q, overflow_d;

  state_e               state_q, state_d;
  logic                 tx_q, tx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic                 stopcnt_q, stopcnt_d;

  logic push, pop, parity_bit;

  // Status flags come straight from registered count/state, so wr_en never
  // reaches them combinationally.
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign tx_busy    = (state_q != IDLE) || !fifo_empty;
  assign tx         = tx_q;
  assign overflow   = overflow_q;

  // A write while full is dropped even if the FSM pops in the same cycle.
  assign push = wr_en && !fifo_full;
  // The IDLE pop does not wait for clken.
  assign pop  = (state_q == IDLE) && !fifo_empty;

  assign parity_bit = (PARITY == 1) ? ~(^shreg_q) : (^shreg_q);

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    overflow_d = wr_en && fifo_full;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: every output of this block gets a default first, so a path that
  // does not assign it cannot infer a latch.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    stopcnt_d = stopcnt_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          shreg_d  = mem_q[rd_ptr_q];
          bitcnt_d = '0;
          state_d  = START;
        end
      end
      START: begin
        if (clken) begin
          tx_d    = 1'b0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (clken) begin
          tx_d = shreg_q[bitcnt_q];
          if (bitcnt_q == LAST_BIT) begin
            stopcnt_d = 1'b0;
            state_d   = (PARITY != 0) ? PAR : STOP;
          end else begin
            bitcnt_d = bitcnt_q + BW'(1);
          end
        end
      end
      PAR: begin
        if (clken) begin
          tx_d    = parity_bit;
          state_d = STOP;
        end
      end
      STOP: begin
        // The first STOP clken raises tx; the STOP_BITS-th returns to IDLE,
        // so the stop level spans STOP_BITS periods before the next start.
        if (clken) begin
          tx_d = 1'b1;
          if (stopcnt_q == LAST_STOP) state_d = IDLE;
          else                        stopcnt_d = stopcnt_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      bitcnt_q   <= '0;
      stopcnt_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      tx_q       <= tx_d;
      bitcnt_q   <= bitcnt_d;
      stopcnt_q  <= stopcnt_d;
    end
  end

  // NOTE: FIFO storage and the shift register carry no reset; the count and
  // FSM state decide whether their contents are ever looked at.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
    shreg_q <= shreg_d;
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg. Three instances: 8N1 (a), 7O1 (b), 8E2 (c).
// A monitor records tx at every clken edge; frames are pulled from those
// records starting at the first start bit and compared with hand-computed
// bit patterns (bit i = level launched on the i-th clken edge of the frame).
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  logic rst_n;
  logic clken = 1'b0;
  logic clken_hold = 1'b0;

  logic [7:0] din_a = '0;
  logic       wr_a = 1'b0;
  logic       tx_a, busy_a, full_a, empty_a, ovf_a;
  logic [6:0] din_b = '0;
  logic       wr_b = 1'b0;
  logic       tx_b, busy_b, full_b, empty_b, ovf_b;
  logic [7:0] din_c = '0;
  logic       wr_c = 1'b0;
  logic       tx_c, busy_c, full_c, empty_c, ovf_c;

  int n_checks = 0;
  int n_err    = 0;

  bit q_a[$];
  bit q_b[$];
  bit q_c[$];

  uart_tx_cfg dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .wr_en(wr_a), .clken(clken),
    .tx(tx_a), .tx_busy(busy_a), .fifo_full(full_a), .fifo_empty(empty_a),
    .overflow(ovf_a)
  );

  uart_tx_cfg #(.DATA_BITS(7), .PARITY(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .wr_en(wr_b), .clken(clken),
    .tx(tx_b), .tx_busy(busy_b), .fifo_full(full_b), .fifo_empty(empty_b),
    .overflow(ovf_b)
  );

  uart_tx_cfg #(.PARITY(2), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .din(din_c), .wr_en(wr_c), .clken(clken),
    .tx(tx_c), .tx_busy(busy_c), .fifo_full(full_c), .fifo_empty(empty_c),
    .overflow(ovf_c)
  );

  initial forever #5 clk = ~clk;

  // clken: one pulse every 4 clk cycles, changed on the falling edge.
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(negedge clk);
      if (clken_hold) begin
        clken = 1'b0;
      end else begin
        phase = (phase + 1) % 4;
        clken = (phase == 0);
      end
    end
  end

  // Record tx of every instance after each clken edge.
  initial forever begin
    @(posedge clk);
    if (clken) begin
      #1;
      q_a.push_back(tx_a);
      q_b.push_back(tx_b);
      q_c.push_back(tx_c);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int q_len(input int w);
    case (w)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  function automatic bit q_head(input int w);
    case (w)
      0:       return q_a[0];
      1:       return q_b[0];
      default: return q_c[0];
    endcase
  endfunction

  function automatic bit q_pop(input int w);
    case (w)
      0:       return q_a.pop_front();
      1:       return q_b.pop_front();
      default: return q_c.pop_front();
    endcase
  endfunction

  task automatic q_clear(input int w);
    case (w)
      0:       q_a.delete();
      1:       q_b.delete();
      default: q_c.delete();
    endcase
  endtask

  function automatic logic get_tx(input int w);
    case (w)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_c;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic get_empty(input int w);
    case (w)
      0:       return empty_a;
      1:       return empty_b;
      default: return empty_c;
    endcase
  endfunction

  // Skip idle-high samples, then collect n consecutive clken-edge levels.
  task automatic take_frame(input int w, input int n, output logic [63:0] v);
    int budget;
    v = '0;
    budget = 0;
    while (1) begin
      while (q_len(w) > 0 && q_head(w) == 1'b1) void'(q_pop(w));
      if (q_len(w) >= n || budget >= 2000) break;
      @(posedge clk);
      #2;
      budget++;
    end
    check("frame_available", 64'(q_len(w) >= n), 64'd1);
    if (q_len(w) >= n)
      for (int i = 0; i < n; i++) v[i] = q_pop(w);
  endtask

  // Present one word for one cycle; returns #1 after the sampling edge.
  task automatic do_write(input int w, input logic [8:0] d);
    @(negedge clk);
    case (w)
      0:       begin din_a = d[7:0]; wr_a = 1'b1; end
      1:       begin din_b = d[6:0]; wr_b = 1'b1; end
      default: begin din_c = d[7:0]; wr_c = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    wr_a = 1'b0;
    wr_b = 1'b0;
    wr_c = 1'b0;
  endtask

  typedef struct {
    int          w;
    logic [8:0]  d;
    int          n;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];
  logic [63:0] v;
  logic [9:0]  burst_exp[5];
  logic [7:0]  burst_dat[6];
  int          bad;

  initial begin
    // Single frames: {which instance, data, frame length, expected levels}.
    vecs[0] = '{0, 9'h055, 10, 64'h2AA};
    vecs[1] = '{0, 9'h000, 10, 64'h200};
    vecs[2] = '{0, 9'h0FF, 10, 64'h3FE};
    vecs[3] = '{0, 9'h0A3, 10, 64'h346};
    vecs[4] = '{1, 9'h003, 10, 64'h306};  // 7O1: odd parity of 0x03 is 1
    vecs[5] = '{1, 9'h007, 10, 64'h20E};  // 7O1: odd parity of 0x07 is 0
    vecs[6] = '{2, 9'h080, 12, 64'hF00};  // 8E2: even parity 1
    vecs[7] = '{2, 9'h000, 12, 64'hC00};  // 8E2: even parity 0

    burst_dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    burst_exp = '{10'h222, 10'h244, 10'h266, 10'h288, 10'h2AA};

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_a", 64'(tx_a), 64'd1);
    check("rst_empty_a", 64'(empty_a), 64'd1);
    check("rst_full_a", 64'(full_a), 64'd0);
    check("rst_busy_a", 64'(busy_a), 64'd0);
    check("rst_ovf_a", 64'(ovf_a), 64'd0);
    check("rst_tx_b", 64'(tx_b), 64'd1);
    check("rst_tx_c", 64'(tx_c), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Table-driven single frames, including the write-to-pop latency.
    for (int i = 0; i < 8; i++) begin
      q_clear(vecs[i].w);
      do_write(vecs[i].w, vecs[i].d);
      check($sformatf("v%0d_accepted_not_empty", i), 64'(get_empty(vecs[i].w)), 64'd0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_popped_empty", i), 64'(get_empty(vecs[i].w)), 64'd1);
      check($sformatf("v%0d_busy", i), 64'(get_busy(vecs[i].w)), 64'd1);
      take_frame(vecs[i].w, vecs[i].n, v);
      check($sformatf("v%0d_frame", i), v, vecs[i].exp);
      check($sformatf("v%0d_idle_busy", i), 64'(get_busy(vecs[i].w)), 64'd0);
      check($sformatf("v%0d_idle_tx", i), 64'(get_tx(vecs[i].w)), 64'd1);
    end

    // 8E2 back-to-back: 0x07 then 0x01; two stop periods, then next start.
    q_clear(2);
    @(negedge clk);
    din_c = 8'h07;
    wr_c  = 1'b1;
    @(posedge clk);
    #1;
    check("e2_first_queued", 64'(empty_c), 64'd0);
    @(negedge clk);
    din_c = 8'h01;
    @(posedge clk);
    #1;
    wr_c = 1'b0;
    check("e2_second_queued", 64'(empty_c), 64'd0);
    take_frame(2, 24, v);
    check("e2_two_frames", v, 64'hE02E0E);
    check("e2_idle_busy", 64'(busy_c), 64'd0);

    // Burst of 6 writes into a depth-4 FIFO: A pops, B..E fill, F dropped.
    q_clear(0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      din_a = burst_dat[k];
      wr_a  = 1'b1;
      @(posedge clk);
      #1;
      if (k == 0) check("burst_k0_empty", 64'(empty_a), 64'd0);
      if (k == 3) check("burst_k3_full", 64'(full_a), 64'd0);
      if (k == 4) check("burst_k4_full", 64'(full_a), 64'd1);
      if (k == 4) check("burst_k4_ovf", 64'(ovf_a), 64'd0);
      if (k == 5) check("burst_k5_ovf", 64'(ovf_a), 64'd1);
      if (k == 5) check("burst_k5_full", 64'(full_a), 64'd1);
    end
    wr_a = 1'b0;
    @(posedge clk);
    #1;
    check("burst_ovf_pulse_end", 64'(ovf_a), 64'd0);
    take_frame(0, 50, v);
    for (int k = 0; k < 5; k++)
      check($sformatf("burst_frame%0d", k), 64'(v[10*k +: 10]), 64'(burst_exp[k]));
    check("burst_idle_busy", 64'(busy_a), 64'd0);
    check("burst_idle_empty", 64'(empty_a), 64'd1);

    // Reset during data bit 3 with two words queued.
    q_clear(0);
    do_write(0, 9'h00F);
    do_write(0, 9'h05A);
    do_write(0, 9'h03C);
    check("rstmid_queued", 64'(empty_a), 64'd0);
    take_frame(0, 5, v);
    check("rstmid_prefix", v, 64'h1E);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_tx", 64'(tx_a), 64'd1);
    check("rstmid_empty", 64'(empty_a), 64'd1);
    check("rstmid_busy", 64'(busy_a), 64'd0);
    check("rstmid_full", 64'(full_a), 64'd0);
    check("rstmid_ovf", 64'(ovf_a), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    q_clear(0);
    repeat (200) @(posedge clk);
    #2;
    bad = 0;
    foreach (q_a[i]) if (q_a[i] == 1'b0) bad++;
    check("rstmid_no_more_frames", 64'(bad), 64'd0);

    // clken held low for 100 cycles mid-frame (0xC5).
    q_clear(0);
    do_write(0, 9'h0C5);
    take_frame(0, 4, v);
    check("freeze_prefix", v, 64'hA);
    clken_hold = 1'b1;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (tx_a !== 1'b1) bad++;
    end
    check("freeze_tx_held", 64'(bad), 64'd0);
    check("freeze_no_clken_edges", 64'(q_a.size()), 64'd0);
    check("freeze_busy", 64'(busy_a), 64'd1);
    clken_hold = 1'b0;
    take_frame(0, 6, v);
    check("freeze_rest", v, 64'h38);
    check("freeze_idle_busy", 64'(busy_a), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
